alu_flag_cond_unit: RTL and testbench

Consumer end of the 16-bit complement adder's flag interface. It latches the adder's N/Z/C/V outputs into a status-flag register on a flag-write strobe. It evaluates 4-bit branch condition codes against those flags and returns a registered taken/not-taken result. It also holds a small flag save/restore stack for interrupt entry and exit. It sits between the ALU (adder Z, C, V, Y[15]) and the PC/branch logic of the single-cycle RISC.

---
 rtl/alu_flag_cond_unit_pkg.sv | 28 ++
 rtl/alu_flag_cond_unit_cond_eval.sv | 41 ++++
 rtl/alu_flag_cond_unit.sv | 104 ++++++++++
 tb/tb_alu_flag_cond_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_flag_cond_unit_pkg.sv
// Shared definitions for the ALU flag/condition unit: condition codes and flag bit positions.
package alu_flag_cond_unit_pkg;

    // Branch condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_flag_cond_unit_cond_eval.sv
// Purely combinational branch-condition evaluator: {N,Z,C,V} flags + 4-bit code -> taken.
module alu_flag_cond_unit_cond_eval
    import alu_flag_cond_unit_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic n, z, c, v;

    assign n = flags[FLG_N];
    assign z = flags[FLG_Z];
    assign c = flags[FLG_C];
    assign v = flags[FLG_V];

    // Decode the condition code against the supplied flags
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_cond_unit.sv
// Status-flag register, flag save/restore stack and registered branch-condition result.
module alu_flag_cond_unit
    import alu_flag_cond_unit_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4,
    parameter bit          FWD_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       n_in,
    input  logic       z_in,
    input  logic       c_in,
    input  logic       v_in,
    input  logic       flag_we,
    input  logic       cond_valid,
    input  logic [3:0] cond,
    input  logic       push,
    input  logic       pop,
    output logic [3:0] flags,
    output logic       taken,
    output logic       taken_valid,
    output logic       stk_empty,
    output logic       stk_full,
    output logic       stk_err
);

    // sp counts entries, so it needs to reach STACK_DEPTH itself
    localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW = $clog2(STACK_DEPTH);

    logic [3:0]     flags_q, flags_d;
    logic [SpW-1:0] sp_q, sp_d, pop_sp;
    logic [3:0]     stack_q [STACK_DEPTH];
    logic           err_q, err_d;
    logic           taken_q, taken_d;
    logic           valid_q;
    logic           push_ok, pop_ok;
    logic [3:0]     eval_flags;
    logic           eval_taken;

    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SpW'(STACK_DEPTH));

    // Stack legality, next pointer, next flags (pop beats flag write) and next result
    always_comb begin
        push_ok = push & ~pop & ~stk_full;
        pop_ok  = pop & ~push & ~stk_empty;
        err_d   = (push & pop) | (push & stk_full) | (pop & stk_empty);
        pop_sp  = sp_q - SpW'(1);

        sp_d = sp_q;
        if (push_ok) begin
            sp_d = sp_q + SpW'(1);
        end else if (pop_ok) begin
            sp_d = pop_sp;
        end

        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = stack_q[pop_sp[IdxW-1:0]];
        end else if (flag_we) begin
            flags_d = {n_in, z_in, c_in, v_in};
        end

        eval_flags = FWD_EN ? flags_d : flags_q;
        taken_d    = cond_valid ? eval_taken : taken_q;
    end

    alu_flag_cond_unit_cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (cond),
        .taken (eval_taken)
    );

    // Control state: flags, stack pointer, error pulse and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            sp_q    <= '0;
            err_q   <= 1'b0;
            taken_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            taken_q <= taken_d;
            valid_q <= cond_valid;
        end
    end

    // Stack storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_q[sp_q[IdxW-1:0]] <= flags_q;
        end
    end

    assign flags       = flags_q;
    assign taken       = taken_q;
    assign taken_valid = valid_q;
    assign stk_err     = err_q;

endmodule

// File: tb/tb_alu_flag_cond_unit.sv
// Directed, table-driven bench for alu_flag_cond_unit (forwarding and non-forwarding instances).
module tb_alu_flag_cond_unit;

    logic       clk;
    logic       rst_n;
    logic       n_in, z_in, c_in, v_in;
    logic       flag_we, cond_valid, push, pop;
    logic [3:0] cond;

    logic [3:0] flags, flags0;
    logic       taken, taken_valid, stk_empty, stk_full, stk_err;
    logic       taken0, taken_valid0, stk_empty0, stk_full0, stk_err0;

    int n_tests;
    int n_fail;

    alu_flag_cond_unit #(.STACK_DEPTH(4), .FWD_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .n_in        (n_in),
        .z_in        (z_in),
        .c_in        (c_in),
        .v_in        (v_in),
        .flag_we     (flag_we),
        .cond_valid  (cond_valid),
        .cond        (cond),
        .push        (push),
        .pop         (pop),
        .flags       (flags),
        .taken       (taken),
        .taken_valid (taken_valid),
        .stk_empty   (stk_empty),
        .stk_full    (stk_full),
        .stk_err     (stk_err)
    );

    alu_flag_cond_unit #(.STACK_DEPTH(4), .FWD_EN(1'b0)) dut_nofwd (
        .clk         (clk),
        .rst_n       (rst_n),
        .n_in        (n_in),
        .z_in        (z_in),
        .c_in        (c_in),
        .v_in        (v_in),
        .flag_we     (flag_we),
        .cond_valid  (cond_valid),
        .cond        (cond),
        .push        (push),
        .pop         (pop),
        .flags       (flags0),
        .taken       (taken0),
        .taken_valid (taken_valid0),
        .stk_empty   (stk_empty0),
        .stk_full    (stk_full0),
        .stk_err     (stk_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] nzcv;
        logic       cv;
        logic [3:0] cond;
        logic       push;
        logic       pop;
        logic [3:0] e_flags;
        logic       e_taken;
        logic       e_tv;
        logic       e_empty;
        logic       e_full;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] nzcv, input logic cv,
                         input logic [3:0] c, input logic pu, input logic po);
        flag_we    = we;
        {n_in, z_in, c_in, v_in} = nzcv;
        cond_valid = cv;
        cond       = c;
        push       = pu;
        pop        = po;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] nzcv, input logic cv,
                                input logic [3:0] c, input logic pu, input logic po,
                                input logic [3:0] ef, input logic et, input logic etv,
                                input logic ee, input logic efu, input logic eer);
        vec_t r;
        r.we = we; r.nzcv = nzcv; r.cv = cv; r.cond = c; r.push = pu; r.pop = po;
        r.e_flags = ef; r.e_taken = et; r.e_tv = etv;
        r.e_empty = ee; r.e_full = efu; r.e_err = eer;
        return r;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //                we  nzcv   cv cond pu po | flags  tk tv em fu er
        // 8000h result of 4000h+4000h: N=1 V=1 -> GE true, LT false
        vecs.push_back(mk(1, 4'b1001, 0, 4'h0, 0, 0, 4'b1001, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'hA, 0, 0, 4'b1001, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'hB, 0, 0, 4'b1001, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 0, 4'b1001, 0, 0, 1, 0, 0));
        // Same-cycle write forwarded: 0100h-FF00h flags, CC
        vecs.push_back(mk(1, 4'b0000, 1, 4'h3, 0, 0, 4'b0000, 1, 1, 1, 0, 0));
        // Zero result 4000h-4000h: N=0 Z=1 C=1 V=0, forwarded into EQ
        vecs.push_back(mk(1, 4'b0110, 1, 4'h0, 0, 0, 4'b0110, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h8, 0, 0, 4'b0110, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h9, 0, 0, 4'b0110, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'hE, 0, 0, 4'b0110, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'hF, 0, 0, 4'b0110, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h4, 0, 0, 4'b0110, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h5, 0, 0, 4'b0110, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h2, 0, 0, 4'b0110, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h6, 0, 0, 4'b0110, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h7, 0, 0, 4'b0110, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'hC, 0, 0, 4'b0110, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'hD, 0, 0, 4'b0110, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h1, 0, 0, 4'b0110, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 0, 4'b0110, 0, 0, 1, 0, 0));
        // Push / overwrite / pop restores
        vecs.push_back(mk(1, 4'b1001, 0, 4'h0, 0, 0, 4'b1001, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 1, 0, 4'b1001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0110, 0, 4'h0, 0, 0, 4'b0110, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 1, 4'b1001, 0, 0, 1, 0, 0));
        // Pop while empty
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 1, 4'b1001, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 0, 4'b1001, 0, 0, 1, 0, 0));
        // Pop beats same-cycle flag write, also for forwarded evaluation
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 1, 0, 4'b1001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0110, 0, 4'h0, 0, 0, 4'b0110, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 4'h0, 0, 1, 4'b1001, 0, 1, 1, 0, 0));
        // Push with write saves the pre-update flags
        vecs.push_back(mk(1, 4'b0001, 0, 4'h0, 1, 0, 4'b0001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 4'h0, 1, 0, 4'b0010, 0, 0, 0, 0, 0));
        // Push+pop at sp=2: both ignored, write still applies
        vecs.push_back(mk(1, 4'b0011, 0, 4'h0, 1, 1, 4'b0011, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 4'b0100, 0, 4'h0, 1, 0, 4'b0100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0101, 0, 4'h0, 1, 0, 4'b0101, 0, 0, 0, 1, 0));
        // Push while full
        vecs.push_back(mk(1, 4'b0111, 0, 4'h0, 1, 0, 4'b0111, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 0, 4'b0111, 0, 0, 0, 1, 0));
        // Unwind: stack holds 1001, 0001, 0011, 0100 from bottom
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 1, 4'b0100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 4'h1, 0, 1, 4'b0011, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 1, 4'b0001, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 1, 4'b1001, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'h0, 0, 1, 4'b1001, 1, 0, 1, 0, 1));

        drive(0, 4'b0000, 0, 4'h0, 0, 0);
        rst_n = 1'b0;
        #12;
        chk("reset_flags", {4'b0, flags}, 8'h00);
        chk("reset_taken", {6'b0, taken_valid, taken}, 8'h00);
        chk("reset_stack", {5'b0, stk_empty, stk_full, stk_err}, 8'b100);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].nzcv, vecs[i].cv, vecs[i].cond, vecs[i].push, vecs[i].pop);
            tick();
            chk($sformatf("v%0d_flags", i), {4'b0, flags}, {4'b0, vecs[i].e_flags});
            chk($sformatf("v%0d_result", i), {6'b0, taken_valid, taken},
                {6'b0, vecs[i].e_tv, vecs[i].e_taken});
            chk($sformatf("v%0d_stack", i), {6'b0, stk_empty, stk_full},
                {6'b0, vecs[i].e_empty, vecs[i].e_full});
            chk($sformatf("v%0d_err", i), {7'b0, stk_err}, {7'b0, vecs[i].e_err});
        end

        // Forwarded vs registered evaluation
        drive(1, 4'b0010, 0, 4'h0, 0, 0);
        tick();
        drive(1, 4'b0000, 1, 4'h3, 0, 0);
        tick();
        chk("fwd1_cc", {7'b0, taken}, 8'd1);
        chk("fwd0_cc", {7'b0, taken0}, 8'd0);
        chk("fwd0_tv", {7'b0, taken_valid0}, 8'd1);
        drive(1, 4'b0010, 1, 4'h2, 0, 0);
        tick();
        chk("fwd1_cs", {7'b0, taken}, 8'd1);
        chk("fwd0_cs", {7'b0, taken0}, 8'd0);

        // Asynchronous reset while a result is pending
        drive(1, 4'b1111, 0, 4'h0, 1, 0);
        tick();
        chk("prerst_state", {3'b0, flags, stk_empty}, {3'b0, 4'b1111, 1'b0});
        drive(0, 4'b0000, 1, 4'hE, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {4'b0, flags}, 8'h00);
        chk("arst_result", {6'b0, taken_valid, taken}, 8'h00);
        chk("arst_stack", {5'b0, stk_empty, stk_full, stk_err}, 8'b100);
        tick();
        chk("arst_tv_held", {7'b0, taken_valid}, 8'd0);
        drive(0, 4'b0000, 0, 4'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_tv", {7'b0, taken_valid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
